// File: rtl/ibuffer_multi.sv
// Multi-issue instruction buffer: compacts fetch packets into a circular FIFO and feeds decode in order.
// Define IBUF_PERF_EN to add the perf_full_cycles / perf_flushed_insts counters.
module ibuffer_multi #(
   parameter int FETCH_WIDTH = 4,
   parameter int DEQ_WIDTH   = 2,
   parameter int DEPTH       = 16,
   parameter int PC_W        = 64
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic                      enq_valid,
   output logic                      enq_ready,
   input  logic [PC_W-1:0]           enq_pc,
   input  logic [FETCH_WIDTH*32-1:0] enq_inst,
   input  logic [FETCH_WIDTH-1:0]    enq_mask,
   input  logic [FETCH_WIDTH-1:0]    enq_predtaken,
   input  logic [FETCH_WIDTH*32-1:0] enq_predtarget,
   output logic [DEQ_WIDTH-1:0]      deq_valid,
   input  logic                      deq_ready,
   output logic [DEQ_WIDTH*32-1:0]   deq_inst,
   output logic [DEQ_WIDTH*PC_W-1:0] deq_pc,
   output logic [DEQ_WIDTH-1:0]      deq_predtaken,
   output logic [DEQ_WIDTH*32-1:0]   deq_predtarget,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty
`ifdef IBUF_PERF_EN
   ,
   output logic [31:0]               perf_full_cycles,
   output logic [31:0]               perf_flushed_insts
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [31:0]      inst_q       [DEPTH];
   logic [PC_W-1:0]  pc_q         [DEPTH];
   logic             predTaken_q  [DEPTH];
   logic [31:0]      predTarget_q [DEPTH];

   logic [FETCH_WIDTH-1:0] effMask;
   logic [PTR_W-1:0]       writeIdx [FETCH_WIDTH];
   logic [PTR_W-1:0]       readIdx;
   logic [CNT_W-1:0]       nEnq, nDeq;
   logic                   takenSeen;
   logic                   enqFire, deqFire;

   assign enq_ready = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
   assign enqFire   = enq_valid & enq_ready & ~flush;
   assign deqFire   = deq_ready & deq_valid[0];
   assign count     = count_q;
   assign empty     = (count_q == '0);

   // Slots behind the first valid predicted-taken branch are dropped; survivors pack densely from tail.
   always_comb begin
      takenSeen = 1'b0;
      effMask   = '0;
      nEnq      = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         writeIdx[i] = tail_q + nEnq[PTR_W-1:0];
         effMask[i]  = enq_mask[i] & ~takenSeen;
         if (effMask[i]) nEnq = nEnq + CNT_W'(1);
         if (effMask[i] & enq_predtaken[i]) takenSeen = 1'b1;
      end
   end

   always_comb begin
      deq_valid      = '0;
      deq_inst       = '0;
      deq_pc         = '0;
      deq_predtaken  = '0;
      deq_predtarget = '0;
      nDeq           = '0;
      readIdx        = '0;
      for (int i = 0; i < DEQ_WIDTH; i++) begin
         readIdx                    = head_q + PTR_W'(i);
         deq_valid[i]               = (count_q > CNT_W'(i)) & ~flush;
         deq_inst[32*i +: 32]       = inst_q[readIdx];
         deq_pc[PC_W*i +: PC_W]     = pc_q[readIdx];
         deq_predtaken[i]           = predTaken_q[readIdx];
         deq_predtarget[32*i +: 32] = predTarget_q[readIdx];
         if (deq_valid[i]) nDeq = nDeq + CNT_W'(1);
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enqFire) tail_d = tail_q + nEnq[PTR_W-1:0];
         if (deqFire) head_d = head_q + nDeq[PTR_W-1:0];
         count_d = count_q + (enqFire ? nEnq : '0) - (deqFire ? nDeq : '0);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage carries no reset; validity is tracked by head/count alone.
   always_ff @(posedge clock) begin
      if (enqFire) begin
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (effMask[i]) begin
               inst_q[writeIdx[i]]       <= enq_inst[32*i +: 32];
               pc_q[writeIdx[i]]         <= enq_pc + PC_W'(4*i);
               predTaken_q[writeIdx[i]]  <= enq_predtaken[i];
               predTarget_q[writeIdx[i]] <= enq_predtarget[32*i +: 32];
            end
         end
      end
   end

`ifdef IBUF_PERF_EN
   logic [31:0] perfFull_q, perfFlushed_q;
   logic [32:0] flushedSum;

   assign flushedSum         = {1'b0, perfFlushed_q} + 33'(count_q);
   assign perf_full_cycles   = perfFull_q;
   assign perf_flushed_insts = perfFlushed_q;

   // Both counters saturate rather than wrap.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         perfFull_q    <= '0;
         perfFlushed_q <= '0;
      end else begin
         if (enq_valid && !enq_ready && (perfFull_q != 32'hFFFF_FFFF))
            perfFull_q <= perfFull_q + 32'd1;
         if (flush)
            perfFlushed_q <= flushedSum[32] ? 32'hFFFF_FFFF : flushedSum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_ibuffer_multi.sv
// Scoreboard bench for ibuffer_multi: a queue-level model predicts each dequeued instruction.
module tb_ibuffer_multi;

   localparam int FW    = 4;
   localparam int DW    = 2;
   localparam int DEPTH = 16;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        taken;
      logic [31:0] target;
   } entry_t;

   logic          clock = 1'b0;
   logic          resetN;
   logic          flush;
   logic          enqValid;
   logic          enqReady;
   logic [63:0]   enqPc;
   logic [127:0]  enqInst;
   logic [3:0]    enqMask;
   logic [3:0]    enqTaken;
   logic [127:0]  enqTarget;
   logic [1:0]    deqValid;
   logic          deqReady;
   logic [63:0]   deqInst;
   logic [127:0]  deqPc;
   logic [1:0]    deqTaken;
   logic [63:0]   deqTarget;
   logic [4:0]    count;
   logic          empty;
`ifdef IBUF_PERF_EN
   logic [31:0]   perfFull;
   logic [31:0]   perfFlushed;
   logic [31:0]   perfFullExp;
   logic [31:0]   perfFlushedExp;
`endif

   entry_t expQ[$];
   entry_t pendQ[$];
   int     checkCount = 0;
   int     failCount  = 0;
   logic   accepted;
   logic [63:0] nextPc;

   always #5 clock = ~clock;

   ibuffer_multi dut (
      .clock          (clock),
      .reset_n        (resetN),
      .flush          (flush),
      .enq_valid      (enqValid),
      .enq_ready      (enqReady),
      .enq_pc         (enqPc),
      .enq_inst       (enqInst),
      .enq_mask       (enqMask),
      .enq_predtaken  (enqTaken),
      .enq_predtarget (enqTarget),
      .deq_valid      (deqValid),
      .deq_ready      (deqReady),
      .deq_inst       (deqInst),
      .deq_pc         (deqPc),
      .deq_predtaken  (deqTaken),
      .deq_predtarget (deqTarget),
      .count          (count),
      .empty          (empty)
`ifdef IBUF_PERF_EN
      ,
      .perf_full_cycles   (perfFull),
      .perf_flushed_insts (perfFlushed)
`endif
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs and records what the buffer should gain from it.
   task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic [3:0] mask,
                                input logic [3:0] taken, input logic fl, input logic dr,
                                output logic acc);
      entry_t e;
      @(posedge clock);
      #1;
      enqValid  = v;
      enqPc     = pc;
      enqMask   = mask;
      enqTaken  = taken;
      flush     = fl;
      deqReady  = dr;
      enqInst   = {$urandom, $urandom, $urandom, $urandom};
      enqTarget = {$urandom, $urandom, $urandom, $urandom};
      pendQ.delete();
      acc = v && !fl && ((DEPTH - expQ.size()) >= FW);
      if (acc) begin
         for (int s = 0; s < FW; s++) begin
            if (mask[s]) begin
               e.pc     = pc + 64'(4 * s);
               e.inst   = enqInst[32*s +: 32];
               e.taken  = taken[s];
               e.target = enqTarget[32*s +: 32];
               pendQ.push_back(e);
               if (taken[s]) break;
            end
         end
      end
   endtask

   // Monitor: compares DUT against the model mid-cycle, pops consumed entries, commits pending ones.
   always @(negedge clock) begin
      entry_t e;
      int     lanes;
      logic [1:0] expValid;
      if (!resetN) begin
         expQ.delete();
         pendQ.delete();
`ifdef IBUF_PERF_EN
         perfFullExp    = '0;
         perfFlushedExp = '0;
`endif
      end else begin
         lanes    = flush ? 0 : ((expQ.size() < DW) ? expQ.size() : DW);
         expValid = '0;
         for (int l = 0; l < lanes; l++) expValid[l] = 1'b1;
         checkOutput("count", 64'(count), 64'(expQ.size()));
         checkOutput("empty", 64'(empty), 64'(expQ.size() == 0));
         checkOutput("enq_ready", 64'(enqReady), 64'((DEPTH - expQ.size()) >= FW));
         checkOutput("deq_valid", 64'(deqValid), 64'(expValid));
         checkOutput("count_bound", 64'(count <= 5'd16), 64'd1);
`ifdef IBUF_PERF_EN
         checkOutput("perf_full", 64'(perfFull), 64'(perfFullExp));
         checkOutput("perf_flushed", 64'(perfFlushed), 64'(perfFlushedExp));
         if (enqValid && ((DEPTH - expQ.size()) < FW) && perfFullExp != 32'hFFFF_FFFF)
            perfFullExp = perfFullExp + 32'd1;
         if (flush) perfFlushedExp = perfFlushedExp + 32'(expQ.size());
`endif
         if (deqReady && lanes > 0) begin
            for (int l = 0; l < lanes; l++) begin
               e = expQ.pop_front();
               checkOutput($sformatf("lane%0d_pc", l), deqPc[64*l +: 64], e.pc);
               checkOutput($sformatf("lane%0d_inst", l), 64'(deqInst[32*l +: 32]), 64'(e.inst));
               checkOutput($sformatf("lane%0d_taken", l), 64'(deqTaken[l]), 64'(e.taken));
               checkOutput($sformatf("lane%0d_target", l), 64'(deqTarget[32*l +: 32]), 64'(e.target));
            end
         end
         if (flush) expQ.delete();
         else foreach (pendQ[k]) expQ.push_back(pendQ[k]);
         pendQ.delete();
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      resetN = 1'b0; flush = 1'b0; enqValid = 1'b0; deqReady = 1'b0;
      enqPc = '0; enqInst = '0; enqMask = '0; enqTaken = '0; enqTarget = '0;
      @(negedge clock);
      checkOutput("reset_count", 64'(count), 64'd0);
      checkOutput("reset_empty", 64'(empty), 64'd1);
      checkOutput("reset_enq_ready", 64'(enqReady), 64'd1);
      checkOutput("reset_deq_valid", 64'(deqValid), 64'd0);
      @(posedge clock);
      #1 resetN = 1'b1;

      applyStimulus(1, 64'h8000_0000, 4'b1111, 4'b0000, 0, 0, accepted);
      applyStimulus(1, 64'h8000_0010, 4'b1100, 4'b0000, 0, 0, accepted);
      @(negedge clock);
      checkOutput("first_count", 64'(count), 64'd4);
      checkOutput("first_lane0_pc", deqPc[63:0], 64'h8000_0000);
      checkOutput("first_lane1_pc", deqPc[127:64], 64'h8000_0004);
      checkOutput("first_deq_valid", 64'(deqValid), 64'd3);
      applyStimulus(1, 64'h8000_0020, 4'b1111, 4'b0010, 0, 0, accepted);
      @(negedge clock);
      checkOutput("partial_mask_count", 64'(count), 64'd6);
      applyStimulus(1, 64'h8000_0030, 4'b1111, 4'b0000, 0, 0, accepted);
      @(negedge clock);
      checkOutput("taken_cut_count", 64'(count), 64'd8);
      applyStimulus(1, 64'h8000_0040, 4'b0001, 4'b0000, 0, 0, accepted);
      applyStimulus(1, 64'h8000_0050, 4'b1111, 4'b0000, 0, 0, accepted);
      @(negedge clock);
      checkOutput("fill_count", 64'(count), 64'd13);
      checkOutput("fill_enq_ready", 64'(enqReady), 64'd0);
      applyStimulus(1, 64'h8000_0050, 4'b1111, 4'b0000, 0, 0, accepted);
      @(negedge clock);
      checkOutput("fill_hold_count", 64'(count), 64'd13);

      nextPc = 64'h8000_0050;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(1, nextPc, 4'b1111, 4'b0000, 0, 1, accepted);
         if (accepted) nextPc = nextPc + 64'd16;
      end

      applyStimulus(0, 64'h0, 4'b0000, 4'b0000, 1, 0, accepted);
      applyStimulus(1, 64'h9000_0000, 4'b1111, 4'b0000, 0, 0, accepted);
      applyStimulus(1, 64'h9000_0010, 4'b0011, 4'b0000, 0, 0, accepted);
      applyStimulus(1, 64'h9000_0020, 4'b1111, 4'b0000, 1, 1, accepted);
      @(negedge clock);
      checkOutput("flush_count_before", 64'(count), 64'd6);
      checkOutput("flush_deq_valid", 64'(deqValid), 64'd0);
      applyStimulus(0, 64'h0, 4'b0000, 4'b0000, 0, 0, accepted);
      @(negedge clock);
      checkOutput("flush_count_after", 64'(count), 64'd0);
      checkOutput("flush_empty_after", 64'(empty), 64'd1);

      for (int c = 0; c < 400; c++) begin
         applyStimulus(logic'($urandom_range(0, 3) != 0), {$urandom, $urandom} & ~64'hF,
                       4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                       logic'($urandom_range(0, 31) == 0), logic'($urandom_range(0, 1)),
                       accepted);
      end
      for (int c = 0; c < 12; c++)
         applyStimulus(0, 64'h0, 4'b0000, 4'b0000, 0, 1, accepted);
      @(negedge clock);
      checkOutput("drain_empty", 64'(empty), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/ibuffer_multi.md
Name: ibuffer_multi

Overview:
- Parametrised multi-issue instruction buffer between the IFU fetch stage and decode.
- Accepts one 128-bit fetch packet per cycle (FETCH_WIDTH slots with per-slot valid mask and branch prediction).
- Compacts the valid slots into a circular FIFO and presents up to DEQ_WIDTH in-order instructions per cycle.
- Flushes on redirect. Successor to the single-lane ibuffer output path.

Parameters:
- FETCH_WIDTH, 4: instruction slots per fetch packet (32-bit each).
- DEQ_WIDTH, 2: instructions presented to decode per cycle; must be <= FETCH_WIDTH.
- DEPTH, 16: FIFO entries; power of two; must be >= 2*FETCH_WIDTH.
- PC_W, 64: PC width.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  redirect; discard all contents
- enq_valid  in  1  fetch packet valid
- enq_ready  out  1  buffer can accept a full packet
- enq_pc  in  PC_W  PC of slot 0 (16B-aligned packet base)
- enq_inst  in  FETCH_WIDTH*32  slot i at bits [32i+31:32i]
- enq_mask  in  FETCH_WIDTH  per-slot valid
- enq_predtaken  in  FETCH_WIDTH  per-slot predicted-taken
- enq_predtarget  in  FETCH_WIDTH*32  per-slot predicted target
- deq_valid  out  DEQ_WIDTH  lane valid, contiguous from lane 0
- deq_ready  in  1  decode consumes all valid lanes this cycle
- deq_inst  out  DEQ_WIDTH*32  lane instructions
- deq_pc  out  DEQ_WIDTH*PC_W  lane PCs
- deq_predtaken  out  DEQ_WIDTH  lane predicted-taken
- deq_predtarget  out  DEQ_WIDTH*32  lane predicted targets
- count  out  clog2(DEPTH)+1  occupied entries
- empty  out  1  count==0

Behaviour:
- Reset (async, reset_n low):
  - head, tail and count clear to 0.
  - empty=1, enq_ready=1, deq_valid=0.
  - Entry storage is not reset.
- enq_ready:
  - Combinational: (DEPTH - count) >= FETCH_WIDTH.
  - Based on current count only; a same-cycle dequeue is not credited.
- Enqueue fires when enq_valid & enq_ready & ~flush.
  - Effective mask: enq_mask with every slot above the lowest slot having both mask=1 and predtaken=1 cleared.
  - Slots after a predicted-taken branch are dropped.
  - Mask need not be contiguous: an unaligned redirect target gives leading zeros.
  - Effective valid slots are written in ascending slot order to tail, tail+1, ... (mod DEPTH).
  - Each entry stores pc = enq_pc + 4*slot, plus inst, predtaken, predtarget.
  - n_enq = popcount(effective mask). tail advances by n_enq.
  - A fire with n_enq=0 is legal and changes nothing.
- Dequeue outputs:
  - Lane i shows entry head+i (mod DEPTH), combinationally from storage.
  - deq_valid[i] = (count > i) & ~flush.
- Dequeue fires when deq_ready & deq_valid[0].
  - n_deq = popcount(deq_valid). head advances by n_deq.
- Count update:
  - Same-cycle enqueue and dequeue allowed: count_next = count + n_enq - n_deq.
  - count never exceeds DEPTH, guaranteed by the enq_ready rule.
- Pointers are clog2(DEPTH) bits and wrap naturally. A packet may straddle the wrap point.
- Flush:
  - Highest priority. head, tail and count clear to 0 next cycle.
  - Same-cycle enqueue and dequeue are ignored; deq_valid is 0 during the flush cycle.
  - enq_ready is unaffected by flush; it still reflects the pre-flush count.
- Latency: an enqueued instruction is visible on deq lanes the cycle after enqueue. No same-cycle bypass.

Optional Feature:
- Macro IBUF_PERF_EN.
- Defined: adds output ports perf_full_cycles[31:0] and perf_flushed_insts[31:0].
  - perf_full_cycles increments each cycle enq_valid & ~enq_ready.
  - perf_flushed_insts adds count on each flush cycle.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, then enq pc=0x80000000, mask=4'b1111, no predtaken, deq_ready=0.
  - Next cycle: count=4; deq lanes show pc 0x80000000 and 0x80000004, deq_valid=2'b11.
- mask=4'b1100, pc=0x80000010.
  - Exactly two entries with pc 0x80000018 and 0x8000001C; count +=2.
- mask=4'b1111, predtaken=4'b0010.
  - Two entries stored (slots 0 and 1); slot 1 entry predtaken=1 with its predtarget.
- Fill to count=13 with deq_ready=0.
  - enq_ready=0; enq_valid ignored; count holds 13.
  - With IBUF_PERF_EN, perf_full_cycles counts those cycles.
- Steady enq 4/cycle with deq_ready=1 for 20 cycles, forcing pointer wrap.
  - PCs dequeue strictly sequential with no loss or duplication; count never exceeds 16.
- count=6 plus simultaneous flush, enq_valid and deq_ready.
  - deq_valid=0 that cycle; next cycle count=0, empty=1.
  - With IBUF_PERF_EN, perf_flushed_insts +=6.
